// File: rtl/echo_ctrl_pkg.sv
// echo_ctrl shared types and widths.
// Imported by the panel controller and its key path.
package echo_ctrl_pkg;

    typedef enum logic [1:0] {
        BYPASS,
        RUN,
        FLUSH
    } state_t;

    localparam int FLUSH_W = 13;
    localparam int PARA_W  = 3;

endpackage

// File: rtl/echo_ctrl_if.sv
// Panel-side bundle: keys and sample tick in,
// echo datapath controls and status out.
interface echo_ctrl_if;
    import echo_ctrl_pkg::*;

    logic              sample_tick;
    logic              key_en_n;
    logic              key_delay_n;
    logic              key_gain_n;
    logic              en;
    logic [PARA_W-1:0] delay_para;
    logic [PARA_W-1:0] gain_para;
    logic              busy;
    logic              user_on;

    modport master (
        output sample_tick,
        output key_en_n,
        output key_delay_n,
        output key_gain_n,
        input  en,
        input  delay_para,
        input  gain_para,
        input  busy,
        input  user_on
    );

    modport slave (
        input  sample_tick,
        input  key_en_n,
        input  key_delay_n,
        input  key_gain_n,
        output en,
        output delay_para,
        output gain_para,
        output busy,
        output user_on
    );

endinterface

// File: rtl/echo_ctrl_key_debounce.sv
// Active-low key: 2-FF synchronizer, stability counter,
// one-clk press pulse on the debounced falling edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // any return to the accepted level restarts the count
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/echo_ctrl.sv
// Echo front-panel controller: keys, parameter registers,
// and bypass-until-refilled handling after delay changes.
module echo_ctrl
    import echo_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DELAY_STEP      = 500,
    parameter int DEF_DELAY       = 3,
    parameter int DEF_GAIN        = 4
) (
    input logic         clk,
    input logic         reset_n,
    echo_ctrl_if.slave  bus
);

    logic p_en;
    logic p_delay;
    logic p_gain;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_en (
        .clk(clk), .reset_n(reset_n),
        .key_n(bus.key_en_n), .press(p_en)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_delay (
        .clk(clk), .reset_n(reset_n),
        .key_n(bus.key_delay_n), .press(p_delay)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_gain (
        .clk(clk), .reset_n(reset_n),
        .key_n(bus.key_gain_n), .press(p_gain)
    );

    state_t             state;
    logic               en;
    logic               busy;
    logic               user_on;
    logic [PARA_W-1:0]  delay_para;
    logic [PARA_W-1:0]  gain_para;
    logic [FLUSH_W-1:0] cnt;
    logic [FLUSH_W-1:0] cnt_nxt;
    logic [FLUSH_W-1:0] target;

    assign cnt_nxt = cnt + FLUSH_W'(1);
    assign target  = FLUSH_W'(DELAY_STEP)
                   * (FLUSH_W'(delay_para) + FLUSH_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BYPASS;
            en         <= 1'b0;
            busy       <= 1'b0;
            user_on    <= 1'b0;
            cnt        <= '0;
            delay_para <= PARA_W'(DEF_DELAY);
            gain_para  <= PARA_W'(DEF_GAIN);
        end else begin
            if (p_gain)
                gain_para <= gain_para + PARA_W'(1);
            if (p_delay)
                delay_para <= delay_para + PARA_W'(1);
            unique case (state)
                BYPASS: begin
                    if (p_en) begin
                        state   <= p_delay ? FLUSH : RUN;
                        en      <= ~p_delay;
                        busy    <= p_delay;
                        user_on <= 1'b1;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    if (p_en) begin
                        state   <= BYPASS;
                        en      <= 1'b0;
                        user_on <= 1'b0;
                    end else if (p_delay) begin
                        state <= FLUSH;
                        en    <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    // en wins; a new delay restarts against the new target
                    if (p_en) begin
                        state   <= BYPASS;
                        busy    <= 1'b0;
                        user_on <= 1'b0;
                        cnt     <= '0;
                    end else if (p_delay) begin
                        cnt <= '0;
                    end else if (bus.sample_tick) begin
                        if (cnt_nxt == target) begin
                            state <= RUN;
                            en    <= 1'b1;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                default: begin
                    state <= BYPASS;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en         = en;
    assign bus.busy       = busy;
    assign bus.user_on    = user_on;
    assign bus.delay_para = delay_para;
    assign bus.gain_para  = gain_para;

endmodule

// File: tb/tb_echo_ctrl.sv
// Bench for echo_ctrl: directed panel scenarios plus random
// key/tick sequences against a press-level model.
module tb_echo_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    echo_ctrl_if bus ();

    echo_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DELAY_STEP(2),
        .DEF_DELAY(3),
        .DEF_GAIN(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // model: user enable, flushing flag, ticks still needed
    bit       m_on;
    bit       m_flush;
    int       m_rem;
    bit [2:0] m_delay;
    bit [2:0] m_gain;

    task automatic model_reset();
        m_on = 0; m_flush = 0; m_rem = 0;
        m_delay = 3'd3; m_gain = 3'd4;
    endtask

    task automatic model_press(input bit e, input bit d, input bit g);
        if (g) m_gain = m_gain + 3'd1;
        if (d) m_delay = m_delay + 3'd1;
        if (e) begin
            if (!m_on) begin
                m_on = 1;
                m_flush = d;
                m_rem = 2 * (int'(m_delay) + 1);
            end else begin
                m_on = 0;
                m_flush = 0;
            end
        end else if (d && m_on) begin
            m_flush = 1;
            m_rem = 2 * (int'(m_delay) + 1);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".en"}, 8'(bus.en), 8'(m_on && !m_flush));
        chk({tag, ".busy"}, 8'(bus.busy), 8'(m_flush));
        chk({tag, ".user_on"}, 8'(bus.user_on), 8'(m_on));
        chk({tag, ".delay"}, 8'(bus.delay_para), 8'(m_delay));
        chk({tag, ".gain"}, 8'(bus.gain_para), 8'(m_gain));
    endtask

    task automatic press(input bit e, input bit d, input bit g);
        @(negedge clk);
        if (e) bus.key_en_n = 1'b0;
        if (d) bus.key_delay_n = 1'b0;
        if (g) bus.key_gain_n = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_en_n = 1'b1;
        bus.key_delay_n = 1'b1;
        bus.key_gain_n = 1'b1;
        repeat (10) @(negedge clk);
        model_press(e, d, g);
    endtask

    task automatic tick();
        repeat (2) @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        if (m_flush) begin
            m_rem--;
            if (m_rem == 0) m_flush = 0;
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all(tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        bus.sample_tick = 1'b0;
        bus.key_en_n = 1'b1;
        bus.key_delay_n = 1'b1;
        bus.key_gain_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // bounces shorter than the debounce window are ignored
        for (int i = 0; i < 5; i++) begin
            bus.key_gain_n = 1'b0;
            repeat (2) @(negedge clk);
            bus.key_gain_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        check_all("bounce_only");
        bus.key_gain_n = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_gain_n = 1'b1;
        repeat (10) @(negedge clk);
        model_press(0, 0, 1);
        check_all("debounce");
        chk("gain_is_5", 8'(bus.gain_para), 8'd5);
        for (int i = 0; i < 8; i++) press(0, 0, 1);
        check_all("gain_wrap");

        press(1, 0, 0);
        check_all("en_on");
        press(1, 0, 0);
        check_all("en_off");

        press(1, 0, 0);
        press(0, 1, 0);
        check_all("flush_enter");
        chk("flush_delay4", 8'(bus.delay_para), 8'd4);
        ticks(10, "flush10");
        chk("flush_done_en", 8'(bus.en), 8'd1);

        press(1, 0, 0);
        for (int i = 0; i < 7; i++) press(0, 1, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        ticks(5, "restart_pre");
        press(0, 1, 0);
        check_all("restart");
        ticks(12, "restart12");

        press(0, 1, 0);
        ticks(4, "gain_pre");
        press(0, 0, 1);
        check_all("gain_in_flush");
        ticks(10, "gain_post");

        press(0, 1, 0);
        ticks(3, "abort_pre");
        press(1, 0, 0);
        check_all("abort");

        press(1, 1, 0);
        check_all("byp_en_delay");
        ticks(4, "byp_flush");
        press(1, 1, 0);
        check_all("run_en_delay");

        press(1, 0, 0);
        press(0, 1, 0);
        ticks(1, "rst_pre");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ticks(12, "rst_post");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: press(1, 0, 0);
                1: press(0, 1, 0);
                2: press(0, 0, 1);
                3: press(1, 1, 0);
                4: press(1, 1, 1);
                default: ticks($urandom_range(1, 6), "rand_tick");
            endcase
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
